wbm_spi_ctrl: RTL and testbench

// Wishbone-domain command sequencer for the SPI slave bridge: parses bytes arriving from
// the SPI RX path, runs single Wishbone master read/write cycles, and returns status and

---
 rtl/wbm_spi_pkg.sv | 25 ++
 rtl/wbm_spi_resp_ser.sv | 65 ++++++
 rtl/wbm_spi_ctrl.sv | 175 +++++++++++++++++
 tb/tb_wbm_spi_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbm_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wbm_spi_pkg
// Brief    : Shared state encoding and frame/status constants for the
//            SPI-to-Wishbone command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package wbm_spi_pkg;

    typedef enum logic [2:0] {
        S_CMD   = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_BUS   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam int CMD_WE_BIT = 7;

    localparam int ST_ERR     = 0;
    localparam int ST_TIMEOUT = 1;
    localparam int ST_OVERRUN = 2;

endpackage
`default_nettype wire

// File: rtl/wbm_spi_resp_ser.sv
`default_nettype none
// ============================================================================
// Module   : wbm_spi_resp_ser
// Brief    : Loads {status, read data} and shifts it out MSB first, one byte
//            per tx_valid/tx_ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module wbm_spi_resp_ser #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_flush,
    input  logic              i_with_data,
    input  logic [7:0]        i_status,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic              i_tx_ready,
    output logic              o_tx_valid,
    output logic [7:0]        o_tx_data,
    output logic              o_status_hs,
    output logic              o_done
);

    localparam int         c_SHIFT_W = DATA_W + 8;
    localparam logic [7:0] c_LAST_RD = 8'(DATA_W / 8);

    logic [c_SHIFT_W-1:0] r_shift;
    logic [7:0]           r_idx;
    logic [7:0]           r_last;
    logic                 r_valid;
    logic                 w_hs;

    always_comb begin
        w_hs        = r_valid && i_tx_ready;
        o_status_hs = w_hs && (r_idx == 8'd0);
        o_done      = w_hs && (r_idx == r_last);
        o_tx_valid  = r_valid;
        o_tx_data   = r_shift[c_SHIFT_W-1 -: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_idx   <= 8'd0;
            r_last  <= 8'd0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= {i_status, i_rdata};
            r_idx   <= 8'd0;
            r_last  <= i_with_data ? c_LAST_RD : 8'd0;
            r_valid <= 1'b1;
        end else if (w_hs) begin
            r_shift <= r_shift << 8;
            r_idx   <= r_idx + 8'd1;
            if (r_idx == r_last) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wbm_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wbm_spi_ctrl
// Brief    : Parses SPI command frames, runs one classic Wishbone master
//            cycle per frame and returns status/read data to the TX path.
// Revision : 1.0 - initial release
// ============================================================================
module wbm_spi_ctrl
    import wbm_spi_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_start,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    input  logic                tx_ready,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i
);

    localparam logic [7:0]  c_ADDR_LAST = 8'(ADDR_W / 8 - 1);
    localparam logic [7:0]  c_DATA_LAST = 8'(DATA_W / 8 - 1);
    localparam logic [15:0] c_TMO_LAST  = 16'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    state_t              w_cur;
    logic                r_we;
    logic [7:0]          r_cnt;
    logic [15:0]         r_tmo;
    logic                r_abort;
    logic [ADDR_W-1:0]   r_adr;
    logic [DATA_W-1:0]   r_wdat;
    logic [DATA_W-1:0]   r_rdat;
    logic [2:0]          r_status;
    logic [2:0]          w_status_nxt;
    logic [DATA_W-1:0]   w_rdat_nxt;
    logic                w_restart;
    logic                w_in_bus;
    logic                w_bus_err;
    logic                w_bus_ack;
    logic                w_bus_tmo;
    logic                w_bus_done;
    logic                w_ser_load;
    logic                w_ser_flush;
    logic                w_ser_done;
    logic                w_status_hs;

    // A restart outside BUS makes this cycle behave as if already in CMD,
    // so a coincident rx_valid byte is parsed as the new command byte.
    always_comb begin
        w_restart   = rx_start && (r_state != S_BUS);
        w_cur       = w_restart ? S_CMD : r_state;
        w_in_bus    = (r_state == S_BUS);
        w_bus_err   = w_in_bus && wbm_err_i;
        w_bus_ack   = w_in_bus && wbm_ack_i && !wbm_err_i;
        w_bus_tmo   = w_in_bus && !wbm_ack_i && !wbm_err_i && (r_tmo == c_TMO_LAST);
        w_bus_done  = w_bus_err || w_bus_ack || w_bus_tmo;
        w_ser_load  = 1'b0;
        w_ser_flush = rx_start && (r_state == S_RESP);
        w_state_nxt = w_cur;
        wbm_cyc_o   = w_in_bus;
        wbm_stb_o   = w_in_bus;
        case (w_cur)
            S_CMD:   if (rx_valid) w_state_nxt = S_ADDR;
            S_ADDR:  if (rx_valid && (r_cnt == c_ADDR_LAST)) w_state_nxt = r_we ? S_WDATA : S_BUS;
            S_WDATA: if (rx_valid && (r_cnt == c_DATA_LAST)) w_state_nxt = S_BUS;
            S_BUS: begin
                if (w_bus_done) begin
                    if (r_abort || rx_start) begin
                        w_state_nxt = S_CMD;
                    end else begin
                        w_state_nxt = S_RESP;
                        w_ser_load  = 1'b1;
                    end
                end
            end
            S_RESP:  if (w_ser_done) w_state_nxt = S_CMD;
            default: w_state_nxt = S_CMD;
        endcase
    end

    // Status is consumed by the status-byte handshake; later events set it again.
    always_comb begin
        w_status_nxt = w_status_hs ? 3'b000 : r_status;
        if (w_bus_err) w_status_nxt[ST_ERR]     = 1'b1;
        if (w_bus_tmo) w_status_nxt[ST_TIMEOUT] = 1'b1;
        if (rx_valid && !w_restart && ((r_state == S_BUS) || (r_state == S_RESP))) begin
            w_status_nxt[ST_OVERRUN] = 1'b1;
        end
        w_rdat_nxt = r_rdat;
        if (w_bus_ack)      w_rdat_nxt = wbm_dat_i;
        else if (w_bus_tmo) w_rdat_nxt = '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CMD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_cnt    <= 8'd0;
            r_tmo    <= 16'd0;
            r_abort  <= 1'b0;
            r_adr    <= '0;
            r_wdat   <= '0;
            r_rdat   <= '0;
            r_status <= 3'b000;
        end else begin
            r_status <= w_status_nxt;
            r_rdat   <= w_rdat_nxt;
            r_tmo    <= w_in_bus ? (r_tmo + 16'd1) : 16'd0;
            r_abort  <= w_in_bus && !w_bus_done && (r_abort || rx_start);
            if (rx_valid) begin
                case (w_cur)
                    S_CMD: begin
                        r_we  <= rx_data[CMD_WE_BIT];
                        r_cnt <= 8'd0;
                    end
                    S_ADDR: begin
                        r_adr <= ADDR_W'({r_adr, rx_data});
                        r_cnt <= (r_cnt == c_ADDR_LAST) ? 8'd0 : (r_cnt + 8'd1);
                    end
                    S_WDATA: begin
                        r_wdat <= DATA_W'({r_wdat, rx_data});
                        r_cnt  <= (r_cnt == c_DATA_LAST) ? 8'd0 : (r_cnt + 8'd1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wbm_we_o  = r_we;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_wdat;
    assign wbm_sel_o = '1;

    wbm_spi_resp_ser #(
        .DATA_W (DATA_W)
    ) u_resp_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_ser_load),
        .i_flush     (w_ser_flush),
        .i_with_data (!r_we),
        .i_status    ({5'b00000, w_status_nxt}),
        .i_rdata     (w_rdat_nxt),
        .i_tx_ready  (tx_ready),
        .o_tx_valid  (tx_valid),
        .o_tx_data   (tx_data),
        .o_status_hs (w_status_hs),
        .o_done      (w_ser_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_wbm_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wbm_spi_ctrl
// Brief    : Directed frames against a transaction-level model of the
//            command sequencer (expected bus cycles and TX byte stream).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wbm_spi_ctrl;

    localparam int TMO = 4;

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
        int          len;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_start, rx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [7:0]  wbm_adr_o;
    logic [31:0] wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i, wbm_err_i;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]  exp_tx[$];
    logic [7:0]  got_tx[$];
    logic [7:0]  lit_q[$];
    txn_t        exp_bus[$];
    logic [2:0]  m_pend = 3'b000;

    int          slv_mode = 0;
    int          slv_delay = 2;
    logic [31:0] slv_rdata = 32'h0;
    int          slv_cnt = 0;

    int          bus_cnt = 0;
    int          cyc_len = 0;
    int          last_len = 0;
    logic [7:0]  last_adr = 8'h0;
    logic [31:0] last_dat = 32'h0;
    logic        last_we = 1'b0;

    wbm_spi_ctrl #(
        .ADDR_W  (8),
        .DATA_W  (32),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_start  (rx_start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Wishbone slave: answers after slv_delay cycles of cyc (mode 0 ack, 1 err, 2 both, 3 silent).
    initial begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = 32'h0;
        forever begin
            @(posedge clk); #1;
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            if (wbm_cyc_o) begin
                slv_cnt++;
                if (slv_cnt == slv_delay && slv_mode != 3) begin
                    wbm_ack_i = (slv_mode == 0 || slv_mode == 2);
                    wbm_err_i = (slv_mode == 1 || slv_mode == 2);
                    wbm_dat_i = slv_rdata;
                end
            end else begin
                slv_cnt = 0;
            end
        end
    end

    // Compare process: every cycle against the expected bus/TX model.
    initial begin
        logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_cyc = 1'b0;
        logic [7:0] prev_data = 8'h0;
        txn_t       cur;
        cur.we = 1'b0; cur.adr = 8'h0; cur.dat = 32'h0; cur.len = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (tx_valid && prev_valid && !prev_ready) chk("tx_stable", tx_data, prev_data);
                if (tx_valid && tx_ready) begin
                    got_tx.push_back(tx_data);
                    chk("tx_byte_expected", exp_tx.size() != 0, 1);
                    if (exp_tx.size() != 0) chk("tx_byte", tx_data, exp_tx.pop_front());
                end
                if (wbm_cyc_o) begin
                    chk("stb", wbm_stb_o, 1);
                    chk("sel", wbm_sel_o, 4'hF);
                    if (!prev_cyc) begin
                        bus_cnt++;
                        cyc_len = 0;
                        chk("bus_expected", exp_bus.size() != 0, 1);
                        if (exp_bus.size() != 0) begin
                            cur = exp_bus.pop_front();
                            chk("bus_adr", wbm_adr_o, cur.adr);
                            chk("bus_we", wbm_we_o, cur.we);
                            if (cur.we) chk("bus_dat", wbm_dat_o, cur.dat);
                        end
                        last_adr = wbm_adr_o;
                        last_dat = wbm_dat_o;
                        last_we  = wbm_we_o;
                    end
                    cyc_len++;
                end else begin
                    chk("stb_idle", wbm_stb_o, 0);
                    if (prev_cyc) begin
                        last_len = cyc_len;
                        chk("cyc_len", cyc_len, cur.len);
                    end
                end
                prev_valid = tx_valid;
                prev_ready = tx_ready;
                prev_data  = tx_data;
                prev_cyc   = wbm_cyc_o;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        rx_start = 1'b1;
        @(posedge clk); #1;
        rx_start = 1'b0;
    endtask

    // Model: the response is {pending|this frame's status, read data or all ones on timeout}.
    task automatic start_frame(input bit we, input logic [7:0] adr, input logic [31:0] wdat,
                               input int mode, input int dly, input logic [31:0] rdat,
                               input bit ovr, input bit resp);
        logic [2:0]  st;
        logic [31:0] rd;
        txn_t        t;
        st = m_pend | {ovr, (mode == 3), (mode == 1 || mode == 2)};
        t.we = we; t.adr = adr; t.dat = wdat; t.len = (mode == 3) ? TMO : dly;
        exp_bus.push_back(t);
        rd = (mode == 3) ? 32'hFFFF_FFFF : rdat;
        if (resp) begin
            m_pend = 3'b000;
            exp_tx.push_back({5'b00000, st});
            if (!we) for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[i*8 +: 8]);
        end else begin
            m_pend = st;
        end
        slv_mode = mode; slv_delay = dly; slv_rdata = rdat;
        send_byte(we ? 8'h80 : 8'h00);
        send_byte(adr);
        if (we) for (int i = 3; i >= 0; i--) send_byte(wdat[i*8 +: 8]);
        if (ovr) begin
            for (int k = 0; k < 20 && !wbm_cyc_o; k++) begin @(posedge clk); #1; end
            chk("ovr_cyc_seen", wbm_cyc_o, 1);
            send_byte(8'h5A);
        end
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0 || wbm_cyc_o || tx_valid) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        chk({nm, "_in_time"}, k < 300, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string nm);
        chk({nm, "_len"}, got_tx.size(), lit_q.size());
        for (int i = 0; i < lit_q.size() && i < got_tx.size(); i++) chk(nm, got_tx[i], lit_q[i]);
        got_tx.delete();
    endtask

    initial begin
        int b0;
        rst_n = 1'b0; rx_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h0; tx_ready = 1'b1;
        #3;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_we", wbm_we_o, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_dat", wbm_dat_o, 0);
        chk("rst_sel", wbm_sel_o, 4'hF);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Write, ack after 2 cycles.
        start_frame(1, 8'h10, 32'hDEADBEEF, 0, 2, 32'h0, 0, 1);
        wait_idle("wr");
        chk("wr_adr", last_adr, 8'h10);
        chk("wr_dat", last_dat, 32'hDEADBEEF);
        chk("wr_we", last_we, 1);
        chk("wr_len", last_len, 2);
        lit_q = {8'h00};
        check_lit("wr_tx");

        // Read with a 5-cycle TX stall mid-response.
        start_frame(0, 8'h20, 32'h0, 0, 2, 32'h12345678, 0, 1);
        for (int k = 0; k < 100 && got_tx.size() < 2; k++) begin @(posedge clk); #1; end
        tx_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 tx_ready = 1'b1;
        wait_idle("rd");
        lit_q = {8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
        check_lit("rd_tx");

        // Read with no response from the slave.
        start_frame(0, 8'h24, 32'h0, 3, 2, 32'h0, 0, 1);
        wait_idle("tmo");
        chk("tmo_len", last_len, TMO);
        lit_q = {8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        check_lit("tmo_tx");

        // ack and err together count as err; the following frame is clean.
        start_frame(1, 8'h11, 32'h01020304, 2, 2, 32'h0, 0, 1);
        wait_idle("err");
        lit_q = {8'h01};
        check_lit("err_tx");
        start_frame(0, 8'h30, 32'h0, 0, 1, 32'h0BADF00D, 0, 1);
        wait_idle("after_err");
        lit_q = {8'h00, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
        check_lit("after_err_tx");

        // Partial write frame abandoned by rx_start.
        b0 = bus_cnt;
        send_byte(8'h80); send_byte(8'h10); send_byte(8'hDE);
        pulse_start();
        start_frame(0, 8'h21, 32'h0, 0, 2, 32'hCAFEF00D, 0, 1);
        wait_idle("restart");
        chk("restart_bus_count", bus_cnt - b0, 1);
        lit_q = {8'h00, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        check_lit("restart_tx");

        // Byte arriving during BUS sets overrun.
        start_frame(0, 8'h40, 32'h0, 0, 3, 32'h11223344, 1, 1);
        wait_idle("ovr");
        lit_q = {8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        check_lit("ovr_tx");

        // rx_start during RESP drops the response.
        tx_ready = 1'b0;
        start_frame(0, 8'h50, 32'h0, 0, 2, 32'h99AABBCC, 0, 0);
        for (int k = 0; k < 50 && !tx_valid; k++) begin @(posedge clk); #1; end
        chk("abort_valid_seen", tx_valid, 1);
        chk("abort_status", tx_data, 8'h00);
        pulse_start();
        chk("abort_tx_low", tx_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_tx_still_low", tx_valid, 0);
        tx_ready = 1'b1;
        got_tx.delete();
        start_frame(0, 8'h60, 32'h0, 0, 2, 32'h55667788, 0, 1);
        wait_idle("post_abort");
        lit_q = {8'h00, 8'h55, 8'h66, 8'h77, 8'h88};
        check_lit("post_abort_tx");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
